n3l_pair_sequencer: RTL and testbench
=====================================

Name: n3l_pair_sequencer

Overview:
- Upstream stage of the N3L cell filter.
- Walks every reference cell of a cubic, periodic cell universe (UNIVERSE_SIZE cells per axis), in linear index order.
- For each reference cell, walks the 27 neighbour offsets (dx,dy,dz each in {-1,0,+1}) and emits one (reference, neighbor) cell-index pair per offset, with neighbour coordinates wrapped periodically.
- Pairs leave on a valid/ready stream that feeds the N3L filter and the cell-pair memory fetch.

Parameters:
- UNIVERSE_SIZE, 3, cells per axis; legal range 3..1023. Values below 3 would alias wrapped neighbours and are not supported.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a full sweep; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final pair handshake
- pair_valid  out  1  pair outputs hold a valid pair
- pair_ready  in  1  consumer accepts the pair when pair_valid && pair_ready
- reference  out  32  linear reference cell index = x + y*N + z*N*N
- neighbor  out  32  linear wrapped neighbour cell index, same encoding
- offset_idx  out  5  k = (dz+1)*9 + (dy+1)*3 + (dx+1), range 0..26; self is k=13
- ref_last  out  1  current pair is the last emitted pair for this reference
- sweep_last  out  1  current pair is the last pair of the sweep

Behaviour:
- Reset (synchronous, any state): state=IDLE; busy, done, pair_valid, ref_last, sweep_last = 0; reference, neighbor = 0; offset_idx = 0. Reset mid-sweep abandons the sweep with no done pulse.
- FSM states are IDLE, EMIT and FINISH.
- IDLE:
  - start=1 → EMIT.
  - Reference coordinates load (0,0,0) and the offset loads the first selected k.
  - busy and pair_valid rise on the next cycle, so first-pair latency is 1 cycle.
- EMIT: pair_valid=1. On handshake, advance to the next selected offset.
  - Offset order: dx fastest, then dy, then dz; each axis runs -1, 0, +1.
  - After the last selected offset, reset the offset to the first selected k and advance the reference: x fastest, then y, then z.
  - If the handshake is for the sweep_last pair → FINISH, with pair_valid=0 in the same next cycle.
- FINISH: done=1 for exactly one cycle, busy=0 → IDLE.
- start in EMIT or FINISH is ignored and not queued.
- Throughput is one pair per cycle while pair_ready=1; no bubbles between references.
- Backpressure: while pair_valid && !pair_ready, every output is held stable.
- Coordinates:
  - Kept as per-axis counters; no divide or modulo hardware.
  - Neighbour axis value = c+d, with -1 → N-1 and N → 0.
  - Linear indices are formed by multiply-add of the counters, registered with the rest of the pair, zero-extended to 32 bits.
- Flags:
  - ref_last=1 when the offset is the last selected k.
  - sweep_last = ref_last && reference == N^3-1.
- Pair counts: 27*N^3 per sweep without the feature; 729 for N=3.

Optional Feature:
- Macro: N3L_HALF_SHELL_EN.
- Defined: only half-shell offsets are emitted, where dx>0, or (dx==0 && dy>0), or (dx==0 && dy==0 && dz>=0).
  - That is 14 offsets per reference including self; 378 pairs for N=3.
  - Skipped offsets cost no cycles; the next-offset logic jumps directly.
  - The first selected k is 2 and the last is 26.
  - ref_last and sweep_last apply to the filtered sequence.
- Undefined: all 27 offsets are emitted and downstream filtering decides. The first k is 0 and the last is 26.

Test Plan:
- Assert rst for 2 cycles, N=3 → every output is 0, busy=0 and done never pulses.
- start pulse with pair_ready tied 1 → first pair ref=0, nbr=26, k=0 one cycle later; exactly 729 handshakes; done pulses once, 1 cycle after the handshake with sweep_last=1.
- Wrap check → ref=26 (2,2,2) with k=26 gives nbr=0; ref=0 with k=13 gives nbr=0; ref=4 (1,1,0) with k=4 gives nbr=22.
- Backpressure: deassert pair_ready for 5 cycles mid-sweep → outputs are frozen; the sequence after release is identical to the unstalled run, with no pair lost or repeated; start pulses during the stall are ignored.
- Reset mid-sweep at pair 300, then start again → IDLE with no done pulse; the new sweep restarts at ref=0, k=0.
- With N3L_HALF_SHELL_EN defined → the first pair is ref=0, k=2, nbr=25; 378 handshakes; every reference emits 14 pairs including k=13.

Source files
------------

// File: rtl/n3l_pair_sequencer.sv
// n3l_pair_sequencer: (reference, neighbour) cell-pair stream over a periodic cube; N3L_HALF_SHELL_EN selects half-shell offsets
module n3l_pair_sequencer #(
  parameter int UNIVERSE_SIZE = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pair_valid,
  input  logic        pair_ready,
  output logic [31:0] reference,
  output logic [31:0] neighbor,
  output logic [4:0]  offset_idx,
  output logic        ref_last,
  output logic        sweep_last
);
  localparam int CW = $clog2(UNIVERSE_SIZE);
  localparam logic [CW-1:0] TOP = CW'(UNIVERSE_SIZE - 1);
  localparam logic [1:0] IDLE = 2'd0, EMIT = 2'd1, FINISH = 2'd2;
  localparam logic [4:0] LAST_K = 5'd26;
`ifdef N3L_HALF_SHELL_EN
  localparam logic [4:0] FIRST_K = 5'd2;
`else
  localparam logic [4:0] FIRST_K = 5'd0;
`endif
  // {dz+1, dy+1, dx+1} from k using compares only
  function automatic logic [5:0] dec(input logic [4:0] k);
    logic [4:0] r;
    logic [1:0] ez, ey, ex;
    ez = k >= 5'd18 ? 2'd2 : k >= 5'd9 ? 2'd1 : 2'd0;
    r  = k >= 5'd18 ? k - 5'd18 : k >= 5'd9 ? k - 5'd9 : k;
    ey = r >= 5'd6 ? 2'd2 : r >= 5'd3 ? 2'd1 : 2'd0;
    ex = 2'(r >= 5'd6 ? r - 5'd6 : r >= 5'd3 ? r - 5'd3 : r);
    return {ez, ey, ex};
  endfunction
  function automatic logic [CW-1:0] wrap(input logic [CW-1:0] c, input logic [1:0] e);
    return e == 2'd0 ? (c == '0 ? TOP : c - CW'(1)) : e == 2'd2 ? (c == TOP ? '0 : c + CW'(1)) : c;
  endfunction
  function automatic logic [31:0] lin(input logic [CW-1:0] x, input logic [CW-1:0] y, input logic [CW-1:0] z);
    return 32'(x) + 32'(y) * 32'(UNIVERSE_SIZE) + 32'(z) * 32'(UNIVERSE_SIZE * UNIVERSE_SIZE);
  endfunction
`ifdef N3L_HALF_SHELL_EN
  function automatic logic sel(input logic [4:0] k);
    logic [5:0] e;
    e = dec(k);
    return e[1:0] == 2'd2 || (e[1:0] == 2'd1 && (e[3:2] == 2'd2 || (e[3:2] == 2'd1 && e[5:4] != 2'd0)));
  endfunction
  // skipped offsets are jumped over in one step
  function automatic logic [4:0] next_k(input logic [4:0] k);
    logic [4:0] n;
    n = LAST_K;
    for (int j = 26; j >= 0; j--) if (5'(j) > k && sel(5'(j))) n = 5'(j);
    return n;
  endfunction
`else
  function automatic logic [4:0] next_k(input logic [4:0] k);
    return k + 5'd1;
  endfunction
`endif
  logic [1:0] state;
  logic [CW-1:0] x, y, z, cx, cy, cz;
  logic [4:0] k, ck;
  logic [5:0] ce;
  logic kl, xl, yl;
  // candidate counters for the next pair: origin from IDLE, else step offset then x, y, z
  always_comb begin
    kl = k == LAST_K;
    xl = kl && x == TOP;
    yl = xl && y == TOP;
    ck = state == IDLE || kl ? FIRST_K : next_k(k);
    cx = state == IDLE ? '0 : kl ? (x == TOP ? '0 : x + CW'(1)) : x;
    cy = state == IDLE ? '0 : xl ? (y == TOP ? '0 : y + CW'(1)) : y;
    cz = state == IDLE ? '0 : yl ? (z == TOP ? '0 : z + CW'(1)) : z;
    ce = dec(ck);
  end
  // FSM plus registered pair; outputs only change on start or handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      pair_valid <= 1'b0;
      ref_last <= 1'b0;
      sweep_last <= 1'b0;
      reference <= '0;
      neighbor <= '0;
      offset_idx <= '0;
      x <= '0;
      y <= '0;
      z <= '0;
      k <= '0;
    end else begin
      done <= 1'b0;
      if ((state == IDLE && start) || (state == EMIT && pair_ready && !sweep_last)) begin
        state <= EMIT;
        busy <= 1'b1;
        pair_valid <= 1'b1;
        x <= cx;
        y <= cy;
        z <= cz;
        k <= ck;
        reference <= lin(cx, cy, cz);
        neighbor <= lin(wrap(cx, ce[1:0]), wrap(cy, ce[3:2]), wrap(cz, ce[5:4]));
        offset_idx <= ck;
        ref_last <= ck == LAST_K;
        sweep_last <= ck == LAST_K && cx == TOP && cy == TOP && cz == TOP;
      end else if (state == EMIT && pair_ready) begin
        state <= FINISH;
        busy <= 1'b0;
        done <= 1'b1;
        pair_valid <= 1'b0;
        ref_last <= 1'b0;
        sweep_last <= 1'b0;
      end else if (state == FINISH) begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_n3l_pair_sequencer.sv
// tb_n3l_pair_sequencer: directed checks of the pair sequencer against an index-arithmetic model
module tb_n3l_pair_sequencer;
  localparam int N = 3;
`ifdef N3L_HALF_SHELL_EN
  localparam logic [127:0] FIRST = {32'd0, 32'd25, 32'd2, 32'd0};
`else
  localparam logic [127:0] FIRST = {32'd0, 32'd26, 32'd0, 32'd0};
`endif
  logic clk = 1'b0;
  logic rst, start, pair_ready;
  logic busy, done, pair_valid, ref_last, sweep_last;
  logic [31:0] reference, neighbor;
  logic [4:0] offset_idx;
  int vectors = 0, miscompares = 0;
  int kl[27];
  int kn;
  int hs, dn, rlc;
  logic fin;
  n3l_pair_sequencer #(.UNIVERSE_SIZE(N)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .pair_valid(pair_valid), .pair_ready(pair_ready), .reference(reference),
    .neighbor(neighbor), .offset_idx(offset_idx), .ref_last(ref_last), .sweep_last(sweep_last)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] pk();
    return {reference, neighbor, 27'd0, offset_idx, 30'd0, ref_last, sweep_last};
  endfunction
  function automatic logic [127:0] model(input int p);
    int r, j, k, x, y, z, nb;
    r = p / kn;
    j = p % kn;
    k = kl[j];
    x = r % N;
    y = (r / N) % N;
    z = r / (N * N);
    nb = (x + k % 3 - 1 + N) % N + ((y + (k / 3) % 3 - 1 + N) % N) * N + ((z + k / 9 - 1 + N) % N) * N * N;
    return {32'(r), 32'(nb), 32'(k), 30'd0, j == kn - 1, j == kn - 1 && r == N * N * N - 1};
  endfunction
  task automatic sweep(input int stall_at, input int rst_at, output int h, output int d, output int rl, output logic f);
    int stall, cyc;
    logic stalled, first;
    h = 0; d = 0; rl = 0; f = 1'b0; stall = 0; cyc = 0; stalled = 1'b0; first = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("first_busy", busy, 1);
    while (!f && cyc < 3000) begin
      if (done) begin
        d++;
        f = 1'b1;
        check("done_busy", {busy, pair_valid}, 0);
      end else if (h == rst_at) begin
        rst = 1'b1;
        pair_ready = 1'b1;
        repeat (2) begin
          @(negedge clk);
          check("rst_ctl", {busy, done, pair_valid}, 0);
        end
        check("rst_out", pk(), 0);
        rst = 1'b0;
        f = 1'b1;
      end else if (pair_valid) begin
        if (first) check("first_pair", pk(), FIRST);
        first = 1'b0;
        if (reference == 26 && offset_idx == 26) check("wrap_hi", neighbor, 0);
        if (reference == 0 && offset_idx == 13) check("wrap_self", neighbor, 0);
        if (reference == 4 && offset_idx == 4) check("wrap_z", neighbor, 22);
        if (h == stall_at && !stalled) begin
          stalled = 1'b1;
          stall = 5;
        end
        check(stall > 0 ? "stall_pair" : "pair", pk(), model(h));
        pair_ready = stall == 0;
        start = stall > 0;
        if (stall > 0) stall--;
        else begin
          if (ref_last) rl++;
          h++;
        end
      end else check("bubble", pair_valid, 1);
      if (!f) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    pair_ready = 1'b1;
    check("sweep_end", f, 1);
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    pair_ready = 1'b1;
    kn = 0;
    for (int k = 0; k < 27; k++) begin
`ifdef N3L_HALF_SHELL_EN
      if (k % 3 == 2 || (k % 3 == 1 && ((k / 3) % 3 == 2 || ((k / 3) % 3 == 1 && k / 9 >= 1)))) begin
        kl[kn] = k;
        kn++;
      end
`else
      kl[kn] = k;
      kn++;
`endif
    end
    repeat (2) @(negedge clk);
    check("reset_out", pk(), 0);
    check("reset_ctl", {busy, done, pair_valid}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_ctl", {busy, done, pair_valid}, 0);
    sweep(-1, -1, hs, dn, rlc, fin);
    check("count", hs, kn * N * N * N);
    check("ref_lasts", rlc, N * N * N);
    check("done_cnt", dn, 1);
    @(negedge clk);
    check("done_pulse", {done, busy}, 0);
    sweep(100, -1, hs, dn, rlc, fin);
    check("stall_count", hs, kn * N * N * N);
    check("stall_done", dn, 1);
    @(negedge clk);
    check("stall_pulse", {done, busy}, 0);
    sweep(-1, 300, hs, dn, rlc, fin);
    check("rst_pairs", hs, 300);
    check("rst_no_done", dn, 0);
    @(negedge clk);
    check("rst_idle", {busy, done, pair_valid}, 0);
    sweep(-1, -1, hs, dn, rlc, fin);
    check("restart_count", hs, kn * N * N * N);
    check("restart_done", dn, 1);
    @(negedge clk);
    check("restart_pulse", {done, busy}, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
